// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the 5x5 inverter and its checker
package matrix_pkg;

    localparam int MAT_N = 5;
    localparam int MAT_W = 32;

    typedef logic [2:0]       idx_t;
    typedef logic [MAT_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } chk_state_t;

endpackage

// File: rtl/inv_check_mac.sv
// rtl/inv_check_mac.sv - combinational multiply with registered, wrapping accumulator
module inv_check_mac #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] acc_q,
    output logic [W-1:0] sum_d
);

    logic [W-1:0] term;
    logic [W-1:0] acc_d;

    // Only the low W bits of the product matter since everything wraps modulo 2^W.
    always_comb begin
        term  = x * y;
        sum_d = acc_q + term;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_inv_check.sv
// rtl/matrix_inv_check.sv - sequential A*INV == d*I checker, one MAC per cycle
module matrix_inv_check
    import matrix_pkg::*;
#(
    parameter int W = MAT_W,
    parameter int N = MAT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] inv_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pass,
    output logic [W-1:0]     scale,
    output idx_t             err_row,
    output idx_t             err_col
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    chk_state_t state_q, state_d;

    logic [W-1:0] a_q   [N][N];
    logic [W-1:0] a_d   [N][N];
    logic [W-1:0] inv_q [N][N];
    logic [W-1:0] inv_d [N][N];

    logic [IW-1:0] r_q, r_d, c_q, c_d, k_q, k_d;

    logic         err_seen_q, err_seen_d;
    idx_t         err_r_q, err_r_d, err_c_q, err_c_d;
    logic [W-1:0] scale_w_q, scale_w_d;

    logic         pass_q, pass_d;
    logic [W-1:0] scale_q, scale_d;
    idx_t         err_row_q, err_row_d, err_col_q, err_col_d;

    logic         xfer, final_cyc, last_elem, at_origin, fail_now;
    logic [W-1:0] acc_q, sum_d;

    assign xfer      = in_valid && (state_q == IDLE);
    assign final_cyc = (state_q == MAC) && (k_q == LAST);
    assign last_elem = final_cyc && (r_q == LAST) && (c_q == LAST);
    assign at_origin = (r_q == '0) && (c_q == '0);

    inv_check_mac #(.W(W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (xfer || final_cyc),
        .en    (state_q == MAC),
        .x     (a_q[r_q][k_q]),
        .y     (inv_q[k_q][c_q]),
        .acc_q (acc_q),
        .sum_d (sum_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = MAC;
            MAC:     if (last_elem) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operands are captured on the transfer edge so the source may move on immediately.
    always_comb begin
        a_d   = a_q;
        inv_d = inv_q;
        if (xfer) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_d[r][c]   = a_flat[(r*N + c)*W +: W];
                    inv_d[r][c] = inv_flat[(r*N + c)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        inv_q <= inv_d;
    end

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        k_d = k_q;
        if (xfer) begin
            r_d = '0;
            c_d = '0;
            k_d = '0;
        end else if (state_q == MAC) begin
            k_d = k_q + IW'(1);
            if (k_q == LAST) begin
                k_d = '0;
                if (c_q == LAST) begin
                    c_d = '0;
                    r_d = (r_q == LAST) ? '0 : r_q + IW'(1);
                end else begin
                    c_d = c_q + IW'(1);
                end
            end
        end
    end

    always_comb begin
        fail_now = 1'b0;
        if (final_cyc) begin
            if (at_origin) begin
                fail_now = (sum_d == '0);
            end else if (r_q == c_q) begin
                fail_now = (sum_d != scale_w_q);
            end else begin
                fail_now = (sum_d != '0);
            end
        end
    end

    // Working state for the current pair; the visible result only updates on entry to DONE.
    always_comb begin
        err_seen_d = err_seen_q;
        err_r_d    = err_r_q;
        err_c_d    = err_c_q;
        scale_w_d  = scale_w_q;
        if (xfer) begin
            err_seen_d = 1'b0;
            err_r_d    = '0;
            err_c_d    = '0;
            scale_w_d  = '0;
        end else begin
            if (fail_now && !err_seen_q) begin
                err_seen_d = 1'b1;
                err_r_d    = idx_t'(r_q);
                err_c_d    = idx_t'(c_q);
            end
            if (final_cyc && at_origin) begin
                scale_w_d = sum_d;
            end
        end
    end

    always_comb begin
        pass_d    = pass_q;
        scale_d   = scale_q;
        err_row_d = err_row_q;
        err_col_d = err_col_q;
        if (last_elem) begin
            pass_d    = !err_seen_d;
            scale_d   = scale_w_d;
            err_row_d = err_seen_d ? err_r_d : '0;
            err_col_d = err_seen_d ? err_c_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            err_seen_q <= 1'b0;
            err_r_q    <= '0;
            err_c_q    <= '0;
            scale_w_q  <= '0;
            pass_q     <= 1'b0;
            scale_q    <= '0;
            err_row_q  <= '0;
            err_col_q  <= '0;
        end else begin
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            err_seen_q <= err_seen_d;
            err_r_q    <= err_r_d;
            err_c_q    <= err_c_d;
            scale_w_q  <= scale_w_d;
            pass_q     <= pass_d;
            scale_q    <= scale_d;
            err_row_q  <= err_row_d;
            err_col_q  <= err_col_d;
        end
    end

    assign pass    = pass_q;
    assign scale   = scale_q;
    assign err_row = err_row_q;
    assign err_col = err_col_q;

endmodule

// File: tb/tb_matrix_inv_check.sv
// tb/tb_matrix_inv_check.sv - scoreboard bench for matrix_inv_check with a matrix-product reference model
module tb_matrix_inv_check;
    import matrix_pkg::*;

    localparam int N   = MAT_N;
    localparam int W   = MAT_W;
    localparam int LAT = N*N*N + 1;

    typedef logic [W-1:0] mat_t [N][N];
    typedef struct {
        logic         pass;
        logic [W-1:0] scale;
        logic [2:0]   er;
        logic [2:0]   ec;
        int           start;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*N*W-1:0] a_flat;
    logic [N*N*W-1:0] inv_flat;
    logic             out_valid;
    logic             out_ready;
    logic             pass;
    logic [W-1:0]     scale;
    idx_t             err_row;
    idx_t             err_col;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    logic out_hold   = 1'b0;
    logic rand_ready = 1'b0;

    matrix_inv_check #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .inv_flat  (inv_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pass      (pass),
        .scale     (scale),
        .err_row   (err_row),
        .err_col   (err_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full matrix product, then a row-major scan against d*I.
    function automatic exp_t model(input mat_t a, input mat_t b);
        exp_t         e;
        logic [W-1:0] p [N][N];
        logic [W-1:0] d;
        logic         bad;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                p[r][c] = '0;
                for (int k = 0; k < N; k++) p[r][c] = p[r][c] + a[r][k] * b[k][c];
            end
        d = p[0][0];
        e.pass = 1'b1; e.scale = d; e.er = '0; e.ec = '0; e.start = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (r == 0 && c == 0) bad = (d == '0);
                else if (r == c)      bad = (p[r][c] != d);
                else                  bad = (p[r][c] != '0);
                if (bad && e.pass) begin
                    e.pass = 1'b0; e.er = 3'(r); e.ec = 3'(c);
                end
            end
        return e;
    endfunction

    function automatic mat_t diag(input logic [W-1:0] v);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m[r][c] = (r == c) ? v : '0;
        return m;
    endfunction

    task automatic launch(input mat_t a, input mat_t b);
        exp_t e;
        bit   ok = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_flat[(r*N + c)*W +: W]   = a[r][c];
                inv_flat[(r*N + c)*W +: W] = b[r][c];
            end
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        e = model(a, b);
        e.start = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < N*N; i++) begin
            a_flat[i*W +: W]   = $urandom;
            inv_flat[i*W +: W] = $urandom;
        end
    endtask

    task automatic wait_done(input int target);
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout: got %0d results expected %0d", done_cnt, target);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = out_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: pops an expectation on each new result and checks hold stability while stalled.
    logic         prev_valid = 1'b0;
    logic         snap_pass;
    logic [W-1:0] snap_scale;
    idx_t         snap_er, snap_ec;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    chk("pass",     W'(pass),    W'(e.pass));
                    chk("scale",    scale,       e.scale);
                    chk("err_row",  W'(err_row), W'(e.er));
                    chk("err_col",  W'(err_col), W'(e.ec));
                    chk("latency",  W'(cyc),     W'(e.start + LAT));
                end
                snap_pass = pass; snap_scale = scale; snap_er = err_row; snap_ec = err_col;
            end else if (out_valid) begin
                chk("hold_pass",  W'(pass),    W'(snap_pass));
                chk("hold_scale", scale,       snap_scale);
                chk("hold_err",   W'({err_row, err_col}), W'({snap_er, snap_ec}));
            end
            if (out_valid) begin
                chk("in_ready_busy", W'(in_ready), 0);
                if (out_ready) done_cnt++;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        mat_t a, b;
        int   nd;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_flat = '0; inv_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  W'(in_ready),  1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_pass",      W'(pass),      0);
        chk("rst_scale",     scale,         0);
        chk("rst_err",       W'({err_row, err_col}), 0);
        rst = 1'b0;

        launch(diag(1), diag(1));                 wait_done(1);
        launch(diag(2), diag(3));                 wait_done(2);
        launch(diag(1), diag(0));                 wait_done(3);
        b = diag(5); b[2][3] = 7;
        launch(diag(1), b);                       wait_done(4);
        b[4][1] = 1;
        launch(diag(1), b);                       wait_done(5);
        a = diag(0); a[0][0] = 32'h8000_0000;
        launch(a, diag(2));                       wait_done(6);

        // Stalled consumer: results must hold while out_ready stays low.
        out_hold = 1'b1;
        b = diag(9); b[1][0] = 4;
        launch(diag(1), b);
        for (int i = 0; i < 1000 && !out_valid; i++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk);
        #1 out_hold = 1'b0;
        wait_done(7);

        launch(diag(2), diag(3));                 wait_done(8);

        // Reset mid-MAC discards the pair and clears the held result.
        launch(diag(1), diag(7));
        repeat (60) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("mid_rst_in_ready",  W'(in_ready),  1);
        chk("mid_rst_out_valid", W'(out_valid), 0);
        chk("mid_rst_pass",      W'(pass),      0);
        chk("mid_rst_scale",     scale,         0);
        chk("mid_rst_err",       W'({err_row, err_col}), 0);
        rst = 1'b0;
        nd = done_cnt;
        launch(diag(1), diag(1));                 wait_done(nd + 1);

        // Random pairs: scaled permutations (pass) with optional corruption, and raw random matrices.
        rand_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            int          perm [N];
            logic [W-1:0] d;
            for (int i = 0; i < N; i++) perm[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                int j = $urandom_range(0, i);
                int s = perm[i];
                perm[i] = perm[j]; perm[j] = s;
            end
            d = $urandom;
            if (t % 4 == 3) d = '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a[r][c] = (perm[r] == c) ? 1 : 0;
                    b[r][c] = (perm[c] == r) ? d : '0;
                end
            if (t % 3 == 1) b[$urandom_range(0, N-1)][$urandom_range(0, N-1)] = $urandom;
            if (t % 5 == 4)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        a[r][c] = $urandom; b[r][c] = $urandom;
                    end
            nd = done_cnt;
            launch(a, b);
            wait_done(nd + 1);
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
